// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, 4-state debounce FSM and
// long-press timer per channel; one-cycle press/release/long pulses plus a debounced level.
module key_filter_multi #(
    parameter int unsigned KEY_NUM  = 4,
    parameter logic        KEY_ACT  = 1'b0,
    parameter int unsigned CNT_MAX  = 999_999,
    parameter int unsigned LONG_MAX = 49_999_999,
    parameter int unsigned CNT_W    = 26
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_MAX);
    localparam logic [CNT_W-1:0] LONG_FIRE = CNT_W'(LONG_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
        logic             sync1_q, sync2_q;
        logic             act;
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] lcnt_q, lcnt_d;
        logic             long_hit;
        logic             press_q, release_q, long_q, level_q;

        assign act      = (sync2_q == KEY_ACT);
        assign long_hit = (lcnt_q == LONG_FIRE);

        // Saturate so the long pulse can only fire once per accepted press.
        always_comb begin
            lcnt_d = lcnt_q;
            if (lcnt_q != LONG_SAT) begin
                lcnt_d = lcnt_q + CNT_ONE;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                sync1_q   <= ~KEY_ACT;
                sync2_q   <= ~KEY_ACT;
                state_q   <= IDLE;
                cnt_q     <= '0;
                lcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                level_q   <= 1'b0;
            end else begin
                sync1_q   <= key_in[g];
                sync2_q   <= sync1_q;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (act) begin
                            state_q <= PRESS_DB;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_DB: begin
                        if (!act) begin
                            state_q <= IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= HELD;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                            lcnt_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    HELD: begin
                        lcnt_q <= lcnt_d;
                        long_q <= long_hit;
                        if (!act) begin
                            state_q <= RELEASE_DB;
                            cnt_q   <= '0;
                        end
                    end
                    RELEASE_DB: begin
                        lcnt_q <= lcnt_d;
                        if (act) begin
                            state_q <= HELD;
                            long_q  <= long_hit;
                        end else if (cnt_q == CNT_LAST) begin
                            // An accepted release wins over a long pulse due on the same edge.
                            state_q   <= IDLE;
                            release_q <= 1'b1;
                            level_q   <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_q + CNT_ONE;
                            long_q <= long_hit;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
        assign key_long[g]    = long_q;
        assign key_state[g]   = level_q;
    end

endmodule
